fibonacci_sequencer: RTL and testbench

//  Initiator side of the begin_fibo/done request protocol. Walks an index range [first_idx..last_idx] and

---
 rtl/fibonacci_sequencer_if.sv | 31 +++
 rtl/fibonacci_sequencer.sv | 155 +++++++++++++++
 tb/tb_fibonacci_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fibonacci_sequencer_if.sv
// Request/result bundle between host control, the Fibonacci responder and the result consumer.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface fibonacci_sequencer_if;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic        busy;
  logic        calc_begin;
  logic [4:0]  calc_input_s;
  logic [15:0] calc_result;
  logic        calc_done;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_index;
  logic [15:0] res_value;
  logic        res_ovf;
  logic        seq_done;
  logic        timeout_err;

  modport master (
    input  start, first_idx, last_idx, calc_result, calc_done, res_ready,
    output busy, calc_begin, calc_input_s, res_valid, res_index, res_value,
           res_ovf, seq_done, timeout_err
  );

  modport slave (
    output start, first_idx, last_idx, calc_result, calc_done, res_ready,
    input  busy, calc_begin, calc_input_s, res_valid, res_index, res_value,
           res_ovf, seq_done, timeout_err
  );
endinterface

// File: rtl/fibonacci_sequencer.sv
// Walks an index range, issues one begin_fibo request per index to a Fibonacci responder and
// streams each result out on a valid/ready port tagged with its index.
module fibonacci_sequencer #(
  parameter int TIMEOUT   = 64,
  parameter int OVF_INDEX = 24
) (
  input logic                   clk,
  input logic                   reset_n,
  fibonacci_sequencer_if.master bus
);
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [4:0]    OVF_IDX_C = 5'(OVF_INDEX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_PUSH   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    last_q, last_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] wait_inc_s;
  logic [CW-1:0] min_wait_s;
  logic          gate_open_s;
  logic          busy_q, busy_d;
  logic          calc_begin_q, calc_begin_d;
  logic [4:0]    calc_input_q, calc_input_d;
  logic          res_valid_q, res_valid_d;
  logic [4:0]    res_index_q, res_index_d;
  logic [15:0]   res_value_q, res_value_d;
  logic          res_ovf_q, res_ovf_d;
  logic          seq_done_q, seq_done_d;
  logic          timeout_err_q, timeout_err_d;

  // A responder's done may still be high from the previous request, so it only counts once
  // the responder has had at least max(idx,1) cycles to produce the new value.
  assign wait_inc_s  = wait_cnt_q + CW'(1'b1);
  assign min_wait_s  = (idx_q == 5'd0) ? CW'(1'b1) : CW'(idx_q);
  assign gate_open_s = bus.calc_done && (wait_cnt_q >= min_wait_s);

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    wait_cnt_d    = wait_cnt_q;
    res_index_d   = res_index_q;
    res_value_d   = res_value_q;
    res_ovf_d     = res_ovf_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d         = bus.first_idx;
          last_d        = bus.last_idx;
          timeout_err_d = 1'b0;
          state_d       = (bus.first_idx > bus.last_idx) ? S_FINISH : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = {CW{1'b0}};
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (gate_open_s) begin
          res_value_d = bus.calc_result;
          res_index_d = idx_q;
          res_ovf_d   = (idx_q > OVF_IDX_C);
          state_d     = S_PUSH;
        end else if (wait_inc_s == TIMEOUT_C) begin
          timeout_err_d = 1'b1;
          state_d       = S_FINISH;
        end else begin
          wait_cnt_d = wait_inc_s;
        end
      end
      S_PUSH: begin
        // Compare before incrementing so last_idx=31 ends without wrapping idx.
        if (bus.res_ready) begin
          if (idx_q == last_q) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_PUSH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    calc_begin_d = (state_d == S_ISSUE);
    calc_input_d = (state_d == S_ISSUE) ? idx_d : calc_input_q;
    res_valid_d  = (state_d == S_PUSH);
    seq_done_d   = (state_d == S_FINISH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 5'd0;
      last_q        <= 5'd0;
      wait_cnt_q    <= {CW{1'b0}};
      busy_q        <= 1'b0;
      calc_begin_q  <= 1'b0;
      calc_input_q  <= 5'd0;
      res_valid_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_value_q   <= 16'd0;
      res_ovf_q     <= 1'b0;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      wait_cnt_q    <= wait_cnt_d;
      busy_q        <= busy_d;
      calc_begin_q  <= calc_begin_d;
      calc_input_q  <= calc_input_d;
      res_valid_q   <= res_valid_d;
      res_index_q   <= res_index_d;
      res_value_q   <= res_value_d;
      res_ovf_q     <= res_ovf_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.calc_begin   = calc_begin_q;
  assign bus.calc_input_s = calc_input_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_index    = res_index_q;
  assign bus.res_value    = res_value_q;
  assign bus.res_ovf      = res_ovf_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Directed bench: table of index ranges with hand-computed results, a sticky-done responder
// model, and hand-written sequences for timeout, empty range and mid-sequence reset.
module tb_fibonacci_sequencer;
  localparam int TIMEOUT   = 64;
  localparam int OVF_INDEX = 24;

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] val;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         stall;
    int         n;
    int         base;
  } seq_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fibonacci_sequencer_if bus ();

  fibonacci_sequencer #(.TIMEOUT(TIMEOUT), .OVF_INDEX(OVF_INDEX)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  res_t res_tab[12];
  seq_t seq_tab[6];

  // Responder: done rises max(idx,1) cycles after begin_fibo and then stays high (sticky),
  // still showing the previous result until the new one is ready.
  function automatic logic [15:0] fib16(input logic [4:0] n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    if (n == 5'd0) return 16'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  logic        mute = 1'b0;
  logic [15:0] rsp_val = 16'd0;
  logic [15:0] rsp_pending = 16'd0;
  logic        rsp_done = 1'b0;
  int          rsp_cnt = 0;
  int          cyc = 0;
  int          begin_cyc = 0;
  int          n_begin = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.calc_begin) begin
      begin_cyc   <= cyc;
      n_begin     <= n_begin + 1;
      rsp_cnt     <= (bus.calc_input_s == 5'd0) ? 1 : int'(bus.calc_input_s);
      rsp_pending <= fib16(bus.calc_input_s);
    end else if (rsp_cnt == 1) begin
      rsp_cnt  <= 0;
      rsp_val  <= rsp_pending;
      rsp_done <= 1'b1;
    end else if (rsp_cnt > 1) begin
      rsp_cnt <= rsp_cnt - 1;
    end
  end

  assign bus.calc_result = rsp_val;
  assign bus.calc_done   = rsp_done & ~mute;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},        32'(bus.busy),         32'd0);
    chk({tag, "_calc_begin"},  32'(bus.calc_begin),   32'd0);
    chk({tag, "_calc_input"},  32'(bus.calc_input_s), 32'd0);
    chk({tag, "_res_valid"},   32'(bus.res_valid),    32'd0);
    chk({tag, "_res_index"},   32'(bus.res_index),    32'd0);
    chk({tag, "_res_value"},   32'(bus.res_value),    32'd0);
    chk({tag, "_res_ovf"},     32'(bus.res_ovf),      32'd0);
    chk({tag, "_seq_done"},    32'(bus.seq_done),     32'd0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err),  32'd0);
  endtask

  task automatic pulse_start(input logic [4:0] first, input logic [4:0] last);
    bus.first_idx = first;
    bus.last_idx  = last;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_seq(input int si);
    seq_t s;
    res_t e;
    int   nb0, nbs, t, lat;
    s = seq_tab[si];
    bus.res_ready = (s.stall == 0);
    nb0 = n_begin;
    pulse_start(s.first, s.last);
    for (int r = 0; r < s.n; r++) begin
      e = res_tab[s.base + r];
      t = 0;
      while (!bus.res_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      lat = (e.idx == 5'd0) ? 1 : int'(e.idx);
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      chk("res_index", 32'(bus.res_index), 32'(e.idx));
      chk("res_value", 32'(bus.res_value), 32'(e.val));
      chk("res_ovf",   32'(bus.res_ovf),   32'(e.ovf));
      chk("latency",   32'(cyc - begin_cyc), 32'(lat + 2));
      if (s.stall > 0) begin
        nbs = n_begin;
        repeat (s.stall) begin
          @(negedge clk);
          chk("hold_valid", 32'(bus.res_valid), 32'd1);
          chk("hold_value", 32'(bus.res_value), 32'(e.val));
        end
        chk("no_issue_in_push", 32'(n_begin), 32'(nbs));
        bus.res_ready = 1'b1;
      end
      @(negedge clk);
      chk("valid_drop", 32'(bus.res_valid), 32'd0);
    end
    t = 0;
    while (!bus.seq_done && t < 10) begin
      @(negedge clk);
      chk("no_extra_result", 32'(bus.res_valid), 32'd0);
      t++;
    end
    chk("seq_done", 32'(bus.seq_done), 32'd1);
    chk("begin_count", 32'(n_begin - nb0), 32'(s.n));
    @(negedge clk);
    chk("seq_done_pulse", 32'(bus.seq_done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int t, nb0;
    logic saw_valid;

    res_tab[0]  = '{5'd3,  16'd2,     1'b0};
    res_tab[1]  = '{5'd4,  16'd3,     1'b0};
    res_tab[2]  = '{5'd5,  16'd5,     1'b0};
    res_tab[3]  = '{5'd6,  16'd8,     1'b0};
    res_tab[4]  = '{5'd0,  16'd1,     1'b0};
    res_tab[5]  = '{5'd1,  16'd1,     1'b0};
    res_tab[6]  = '{5'd24, 16'd46368, 1'b0};
    res_tab[7]  = '{5'd25, 16'd9489,  1'b1};
    res_tab[8]  = '{5'd5,  16'd5,     1'b0};
    res_tab[9]  = '{5'd30, 16'd45608, 1'b1};
    res_tab[10] = '{5'd31, 16'd35549, 1'b1};
    res_tab[11] = '{5'd2,  16'd1,     1'b0};

    seq_tab[0] = '{5'd3,  5'd6,  0, 4, 0};
    seq_tab[1] = '{5'd0,  5'd1,  0, 2, 4};
    seq_tab[2] = '{5'd24, 5'd25, 0, 2, 6};
    seq_tab[3] = '{5'd5,  5'd5,  5, 1, 8};
    seq_tab[4] = '{5'd30, 5'd31, 0, 2, 9};
    seq_tab[5] = '{5'd2,  5'd2,  0, 1, 11};

    bus.start     = 1'b0;
    bus.first_idx = 5'd0;
    bus.last_idx  = 5'd0;
    bus.res_ready = 1'b1;
    reset_n       = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_seq(i);

    // Silent responder: request abandoned after TIMEOUT wait cycles, no result
    mute = 1'b1;
    nb0 = n_begin;
    pulse_start(5'd10, 5'd12);
    t = 0;
    while (!bus.calc_begin && t < 5) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    saw_valid = 1'b0;
    while (!bus.seq_done && t < 100) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.res_valid;
      t++;
    end
    chk("timeout_cycles", 32'(t), 32'(TIMEOUT + 1));
    chk("timeout_seq_done", 32'(bus.seq_done), 32'd1);
    chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    chk("timeout_no_result", 32'(saw_valid), 32'd0);
    chk("timeout_one_begin", 32'(n_begin - nb0), 32'd1);
    mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Empty range: immediate finish, no request, timeout_err cleared by the start
    nb0 = n_begin;
    pulse_start(5'd7, 5'd2);
    t = 0;
    while (!bus.seq_done && t < 2) begin
      @(negedge clk);
      t++;
    end
    chk("empty_seq_done", 32'(bus.seq_done), 32'd1);
    chk("empty_err_clear", 32'(bus.timeout_err), 32'd0);
    chk("empty_no_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk("empty_no_begin", 32'(n_begin - nb0), 32'd0);
    chk("empty_idle", 32'(bus.busy), 32'd0);

    // Reset while waiting on the responder: everything clears at once
    pulse_start(5'd20, 5'd20);
    t = 0;
    while (!bus.calc_begin && t < 5) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    chk("pre_reset_input", 32'(bus.calc_input_s), 32'd20);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.seq_done | bus.busy;
    end
    chk("post_reset_quiet", 32'(saw_valid), 32'd0);

    run_seq(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end
endmodule
